key_debounce_pulse: RTL and testbench

//  Debounces the board push-buttons (active-low, asynchronous) and turns each press into
//  one-clock command pulses, with optional auto-repeat while a key is held. Sits directly

---
 rtl/key_debounce_pulse.sv | 142 ++++++++++++++
 tb/tb_key_debounce_pulse.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// Key debouncer with one-cycle command pulses and optional auto-repeat.
// Each key has its own 2-FF synchroniser, timing counter and five-state FSM.
// A key that is held through reset is treated as a new press once reset lifts.
module key_debounce_pulse #(
  parameter int                N_KEYS       = 4,
  parameter int                DEBOUNCE_CYC = 1_000_000,
  parameter int                HOLD_CYC     = 25_000_000,
  parameter int                REPEAT_CYC   = 5_000_000,
  parameter logic [N_KEYS-1:0] REPEAT_EN    = N_KEYS'(4'b1100)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_pulse,
  output logic [N_KEYS-1:0] key_level
);

  localparam int MAX_AB  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REPEAT,
    RELEASE_DB
  } state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic             sync1;
    logic             s;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             from_repeat;
    logic             next_from_repeat;
    logic             pulse_next;
    logic             pulse_q;
    logic             level_q;

    // Two-stage synchroniser; resets to "released" so a held key looks like a fresh press
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= 1'b1;
        s     <= 1'b1;
      end else begin
        sync1 <= key_in[i];
        s     <= sync1;
      end
    end

    // State, timing counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state       <= IDLE;
        cnt         <= '0;
        from_repeat <= 1'b0;
        pulse_q     <= 1'b0;
        level_q     <= 1'b0;
      end else begin
        state       <= next_state;
        cnt         <= next_cnt;
        from_repeat <= next_from_repeat;
        pulse_q     <= pulse_next;
        level_q     <= (next_state == PRESSED) || (next_state == REPEAT) ||
                       (next_state == RELEASE_DB);
      end
    end

    // Next-state logic: a high s always wins over a timer expiry in the pressed states
    always_comb begin
      next_state       = state;
      next_cnt         = cnt + CNT_W'(1);
      next_from_repeat = from_repeat;
      pulse_next       = 1'b0;
      case (state)
        IDLE: begin
          next_cnt = '0;
          if (!s) next_state = PRESS_DB;
        end
        PRESS_DB: begin
          if (s) begin
            next_state = IDLE;
            next_cnt   = '0;
          end else if (cnt == DB_LAST) begin
            next_state = PRESSED;
            next_cnt   = '0;
            pulse_next = 1'b1;
          end
        end
        PRESSED: begin
          if (s) begin
            next_state       = RELEASE_DB;
            next_cnt         = '0;
            next_from_repeat = 1'b0;
          end else if (REPEAT_EN[i]) begin
            if (cnt == HOLD_LAST) begin
              next_state = REPEAT;
              next_cnt   = '0;
              pulse_next = 1'b1;
            end
          end else begin
            next_cnt = cnt;
          end
        end
        REPEAT: begin
          if (s) begin
            next_state       = RELEASE_DB;
            next_cnt         = '0;
            next_from_repeat = 1'b1;
          end else if (cnt == REP_LAST) begin
            next_cnt   = '0;
            pulse_next = 1'b1;
          end
        end
        RELEASE_DB: begin
          if (!s) begin
            next_state = from_repeat ? REPEAT : PRESSED;
            next_cnt   = '0;
          end else if (cnt == DB_LAST) begin
            next_state = IDLE;
            next_cnt   = '0;
          end
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end

    assign key_pulse[i] = pulse_q;
    assign key_level[i] = level_q;
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse: directed scenarios with fixed
// expected pulse edges, then random key activity against a timestamp-based model.
module tb_key_debounce_pulse;

  localparam int         NK  = 4;
  localparam int         D   = 8;
  localparam int         H   = 32;
  localparam int         R   = 10;
  localparam logic [3:0] REN = 4'b1100;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_pulse;
  logic [3:0] key_level;

  int total = 0;
  int bad   = 0;

  key_debounce_pulse #(
    .N_KEYS(NK), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .REPEAT_EN(REN)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_pulse(key_pulse), .key_level(key_level)
  );

  // Free-running clock
  always #5 clk = ~clk;

  logic [3:0] m_sync1, m_s, m_last, m_level, m_pulse;
  int         m_run[4];
  int         m_start[4];
  bit         m_rep[4];
  int         t = 0;

  int   rel_edge;
  int   watch;
  int   pulse_edges[$];
  int   lvl_rise, lvl_fall;
  logic [3:0] vec_at10;

  task automatic model_reset();
    m_sync1 = '1; m_s = '1; m_last = '1; m_level = '0; m_pulse = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_start[i] = 0; m_rep[i] = 0;
    end
  endtask

  // Acceptance = D+1 consecutive equal synchronised samples; repeat timing by timestamps
  task automatic model_edge(input logic [3:0] k);
    for (int i = 0; i < 4; i++) begin
      logic smp;
      logic p;
      smp = m_s[i];
      p   = 1'b0;
      if (smp == m_last[i]) m_run[i]++; else m_run[i] = 1;
      m_last[i] = smp;
      if (!m_level[i]) begin
        if (!smp && m_run[i] == D + 1) begin
          m_level[i] = 1'b1; p = 1'b1; m_start[i] = t; m_rep[i] = 0;
        end
      end else if (smp) begin
        if (m_run[i] == D + 1) m_level[i] = 1'b0;
      end else if (m_run[i] == 1) begin
        m_start[i] = t;
      end else if (REN[i]) begin
        if (!m_rep[i] && t - m_start[i] == H) begin
          p = 1'b1; m_rep[i] = 1; m_start[i] = t;
        end else if (m_rep[i] && t - m_start[i] == R) begin
          p = 1'b1; m_start[i] = t;
        end
      end
      m_pulse[i] = p;
    end
    m_s     = m_sync1;
    m_sync1 = k;
  endtask

  task automatic checkOutput();
    total++;
    assert (key_pulse === m_pulse) else begin
      bad++;
      $error("[TB] FAIL pulse t=%0d observed=%b expected=%b", t, key_pulse, m_pulse);
    end
    total++;
    assert (key_level === m_level) else begin
      bad++;
      $error("[TB] FAIL level t=%0d observed=%b expected=%b", t, key_level, m_level);
    end
    if (key_pulse[watch] === 1'b1) pulse_edges.push_back(rel_edge);
    if (key_level[watch] === 1'b1 && lvl_rise < 0) lvl_rise = rel_edge;
    if (key_level[watch] === 1'b0 && lvl_rise >= 0 && lvl_fall < 0) lvl_fall = rel_edge;
    if (rel_edge == 10) vec_at10 = key_pulse;
  endtask

  // Drive inputs at the falling edge, advance one rising edge, check at the next falling edge
  task automatic applyStimulus(input logic r, input logic [3:0] k);
    rst    = r;
    key_in = k;
    if (r) model_reset();
    @(posedge clk);
    if (r) model_reset(); else model_edge(k);
    t++;
    rel_edge++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic beginScenario(input int key);
    applyStimulus(1'b1, '1);
    applyStimulus(1'b1, '1);
    pulse_edges.delete();
    rel_edge = -1;
    lvl_rise = -1;
    lvl_fall = -1;
    vec_at10 = 'x;
    watch    = key;
  endtask

  task automatic checkEdges(input string tag, input int exp[$]);
    total++;
    assert (pulse_edges.size() === exp.size()) else begin
      bad++;
      $error("[TB] FAIL %s pulse count observed=%0d expected=%0d", tag, pulse_edges.size(), exp.size());
    end
    for (int j = 0; j < exp.size() && j < pulse_edges.size(); j++) begin
      total++;
      assert (pulse_edges[j] === exp[j]) else begin
        bad++;
        $error("[TB] FAIL %s pulse[%0d] edge observed=%0d expected=%0d", tag, j, pulse_edges[j], exp[j]);
      end
    end
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    int exp[$];
    logic [3:0] k;
    rst = 1'b1; key_in = '1; watch = 0; rel_edge = 0; lvl_rise = -1; lvl_fall = -1;
    model_reset();

    $display("[TB] scenario 1: single press and release on key 0");
    beginScenario(0);
    for (int e = 0; e < 45; e++) applyStimulus(1'b0, (e < 20) ? 4'b1110 : 4'b1111);
    exp = '{10};
    checkEdges("s1", exp);
    total++;
    assert (lvl_rise === 10) else begin
      bad++; $error("[TB] FAIL s1 level rise observed=%0d expected=10", lvl_rise);
    end
    total++;
    assert (lvl_fall === 30) else begin
      bad++; $error("[TB] FAIL s1 level fall observed=%0d expected=30", lvl_fall);
    end

    $display("[TB] scenario 2: bouncy short press on key 1");
    beginScenario(1);
    for (int e = 0; e < 40; e++)
      applyStimulus(1'b0, (e < 5 || (e >= 8 && e < 13)) ? 4'b1101 : 4'b1111);
    exp = {};
    checkEdges("s2", exp);
    total++;
    assert (lvl_rise === -1) else begin
      bad++; $error("[TB] FAIL s2 level rise observed=%0d expected=-1", lvl_rise);
    end

    $display("[TB] scenario 3: auto-repeat on key 2");
    beginScenario(2);
    for (int e = 0; e < 110; e++) applyStimulus(1'b0, (e < 80) ? 4'b1011 : 4'b1111);
    exp = '{10, 42, 52, 62, 72};
    checkEdges("s3", exp);

    $display("[TB] scenario 4: long hold on non-repeating key 0");
    beginScenario(0);
    for (int e = 0; e < 110; e++) applyStimulus(1'b0, (e < 80) ? 4'b1110 : 4'b1111);
    exp = '{10};
    checkEdges("s4", exp);

    $display("[TB] scenario 5: keys 0 and 3 together");
    beginScenario(3);
    for (int e = 0; e < 40; e++) applyStimulus(1'b0, (e < 20) ? 4'b0110 : 4'b1111);
    exp = '{10};
    checkEdges("s5", exp);
    total++;
    assert (vec_at10 === 4'b1001) else begin
      bad++; $error("[TB] FAIL s5 vector observed=%b expected=1001", vec_at10);
    end

    $display("[TB] scenario 6: reset in the middle of a press");
    beginScenario(0);
    for (int e = 0; e < 40; e++) applyStimulus((e >= 6 && e < 12), 4'b1110);
    exp = '{22};
    checkEdges("s6", exp);

    $display("[TB] scenario 7: release glitch while key 2 is held");
    beginScenario(2);
    for (int e = 0; e < 110; e++)
      applyStimulus(1'b0, (e < 30 || (e >= 33 && e < 80)) ? 4'b1011 : 4'b1111);
    exp = '{10, 67, 77};
    checkEdges("s7", exp);

    $display("[TB] random phase");
    beginScenario(0);
    k = '1;
    for (int e = 0; e < 3000; e++) begin
      logic r;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) k[i] = ~k[i];
      r = ($urandom_range(0, 399) == 0);
      applyStimulus(r, k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
